sort_sequencer: RTL and testbench

Hardware sequencer for the `sort_top` accelerator. It replaces CPU-driven MMIO sequencing of rst/din/now1/now2/y_valid/dout. On a `start` pulse it resets the sorter and streams 2^LOG_INPUT_NUM words from a source buffer into it. It then waits for `y_valid` under a watchdog and drains the sorted words into a destination buffer. It sits between the AXI peripheral's control registers and the sorter and buffers.

---
 rtl/sort_sequencer_pkg.sv | 24 ++
 rtl/sort_sequencer_if.sv | 36 +++
 rtl/sort_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_sort_sequencer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_sequencer_pkg.sv
// Shared definitions for the sort_top sequencer: state encodings, parameter
// defaults and a width helper.
package sort_sequencer_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SRST      = 3'd1;
  localparam logic [2:0] ST_LOAD      = 3'd2;
  localparam logic [2:0] ST_WAIT      = 3'd3;
  localparam logic [2:0] ST_DRAIN_WR  = 3'd4;
  localparam logic [2:0] ST_DRAIN_ADV = 3'd5;
  localparam logic [2:0] ST_FIN       = 3'd6;

  localparam int unsigned DEF_SRT_RST_CYCLES = 2;
  localparam int unsigned DEF_TIMEOUT        = 1024;

  // Ceiling log2, never less than 1 so it can size a register directly.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/sort_sequencer_if.sv
// Control, buffer and sorter signals between the sequencer (master) and its
// surroundings (slave).
interface sort_sequencer_if #(
  parameter int unsigned AW = 3,
  parameter int unsigned DW = 32
);
  logic          start;
  logic          abort;
  logic          busy;
  logic          done;
  logic          err;
  logic          src_rd;
  logic [AW-1:0] src_addr;
  logic [DW-1:0] src_data;
  logic          dst_we;
  logic [AW-1:0] dst_addr;
  logic [DW-1:0] dst_data;
  logic          srt_rst;
  logic          srt_now1;
  logic          srt_now2;
  logic [DW-1:0] srt_din;
  logic          srt_y_valid;
  logic [DW-1:0] srt_dout;

  modport master (
    input  start, abort, src_data, srt_y_valid, srt_dout,
    output busy, done, err, src_rd, src_addr, dst_we, dst_addr, dst_data,
           srt_rst, srt_now1, srt_now2, srt_din
  );

  modport slave (
    output start, abort, src_data, srt_y_valid, srt_dout,
    input  busy, done, err, src_rd, src_addr, dst_we, dst_addr, dst_data,
           srt_rst, srt_now1, srt_now2, srt_din
  );
endinterface

// File: rtl/sort_sequencer.sv
// Job sequencer for sort_top: resets the sorter, streams the source buffer in,
// waits for results under a watchdog and drains them to the destination buffer.
module sort_sequencer
  import sort_sequencer_pkg::*;
#(
  parameter int unsigned LOG_INPUT_NUM  = 3,
  parameter int unsigned DATAWIDTH      = 32,
  parameter int unsigned SRT_RST_CYCLES = DEF_SRT_RST_CYCLES,
  parameter int unsigned TIMEOUT        = DEF_TIMEOUT
) (
  input logic              clk,
  input logic              rst,
  sort_sequencer_if.master bus
);

  localparam int unsigned AW  = LOG_INPUT_NUM;
  localparam int unsigned DW  = DATAWIDTH;
  localparam int unsigned N   = 1 << AW;
  localparam int unsigned WDW = clog2(TIMEOUT + 1);
  localparam int unsigned RCW = clog2(SRT_RST_CYCLES + 1);

  localparam logic [AW-1:0]  IDX_LAST = AW'(N - 1);
  localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT - 1);
  localparam logic [WDW-1:0] WD_MAX   = WDW'(TIMEOUT);
  localparam logic [RCW-1:0] RC_LAST  = RCW'(SRT_RST_CYCLES - 1);

  logic [2:0]     state_q, state_d;
  logic [RCW-1:0] rc_q, rc_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic [AW-1:0]  idx_q, idx_d;
  logic           ret_vld_q, ret_vld_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic           src_rd_q, src_rd_d;
  logic [AW-1:0]  src_addr_q, src_addr_d;
  logic           dst_we_q, dst_we_d;
  logic [AW-1:0]  dst_addr_q, dst_addr_d;
  logic [DW-1:0]  dst_data_q, dst_data_d;
  logic           srt_rst_q, srt_rst_d;
  logic           srt_now1_q, srt_now1_d;
  logic           srt_now2_q, srt_now2_d;
  logic [DW-1:0]  srt_din_q, srt_din_d;

  // Next state and next registered outputs; every output reflects the state being entered.
  always_comb begin
    state_d    = state_q;
    rc_d       = rc_q;
    wd_d       = wd_q;
    idx_d      = idx_q;
    ret_vld_d  = 1'b0;
    done_d     = 1'b0;
    err_d      = err_q;
    src_rd_d   = 1'b0;
    src_addr_d = src_addr_q;
    dst_we_d   = 1'b0;
    dst_addr_d = dst_addr_q;
    dst_data_d = dst_data_q;
    srt_rst_d  = 1'b0;
    srt_now1_d = 1'b0;
    srt_now2_d = 1'b0;
    srt_din_d  = srt_din_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d   = ST_SRST;
          err_d     = 1'b0;
          rc_d      = '0;
          srt_rst_d = 1'b1;
        end
      end
      ST_SRST: begin
        if (rc_q == RC_LAST) begin
          state_d    = ST_LOAD;
          src_rd_d   = 1'b1;
          src_addr_d = '0;
        end else begin
          rc_d      = RCW'(rc_q + 1'b1);
          srt_rst_d = 1'b1;
        end
      end
      ST_LOAD: begin
        // Read return pipe: src_rd -> data valid -> registered into srt_din with now1.
        ret_vld_d  = src_rd_q;
        srt_now1_d = ret_vld_q;
        if (ret_vld_q) srt_din_d = bus.src_data;
        if (src_rd_q && (src_addr_q != IDX_LAST)) begin
          src_rd_d   = 1'b1;
          src_addr_d = AW'(src_addr_q + 1'b1);
        end
        if (srt_now1_q && !ret_vld_q) begin
          state_d = ST_WAIT;
          wd_d    = '0;
        end
      end
      ST_WAIT: begin
        if (bus.srt_y_valid) begin
          state_d    = ST_DRAIN_WR;
          idx_d      = '0;
          dst_we_d   = 1'b1;
          dst_addr_d = '0;
          dst_data_d = bus.srt_dout;
          srt_now2_d = 1'b1;
        end else if (wd_q == WD_LAST) begin
          state_d = ST_FIN;
          err_d   = 1'b1;
          done_d  = 1'b1;
        end else if (wd_q != WD_MAX) begin
          wd_d = WDW'(wd_q + 1'b1);
        end
      end
      ST_DRAIN_WR: begin
        if (idx_q == IDX_LAST) begin
          state_d = ST_FIN;
          done_d  = 1'b1;
        end else begin
          state_d = ST_DRAIN_ADV;
        end
      end
      ST_DRAIN_ADV: begin
        state_d    = ST_DRAIN_WR;
        idx_d      = AW'(idx_q + 1'b1);
        dst_we_d   = 1'b1;
        dst_addr_d = AW'(idx_q + 1'b1);
        dst_data_d = bus.srt_dout;
        srt_now2_d = 1'b1;
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort overrides everything: reset the sorter, drop in-flight reads, keep err.
    if (bus.abort && (state_q != ST_IDLE) && (state_q != ST_FIN)) begin
      state_d    = ST_FIN;
      done_d     = 1'b1;
      err_d      = err_q;
      srt_rst_d  = 1'b1;
      src_rd_d   = 1'b0;
      ret_vld_d  = 1'b0;
      dst_we_d   = 1'b0;
      srt_now1_d = 1'b0;
      srt_now2_d = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rc_q       <= '0;
      wd_q       <= '0;
      idx_q      <= '0;
      ret_vld_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      src_rd_q   <= 1'b0;
      src_addr_q <= '0;
      dst_we_q   <= 1'b0;
      dst_addr_q <= '0;
      dst_data_q <= '0;
      srt_rst_q  <= 1'b0;
      srt_now1_q <= 1'b0;
      srt_now2_q <= 1'b0;
      srt_din_q  <= '0;
    end else begin
      state_q    <= state_d;
      rc_q       <= rc_d;
      wd_q       <= wd_d;
      idx_q      <= idx_d;
      ret_vld_q  <= ret_vld_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      src_rd_q   <= src_rd_d;
      src_addr_q <= src_addr_d;
      dst_we_q   <= dst_we_d;
      dst_addr_q <= dst_addr_d;
      dst_data_q <= dst_data_d;
      srt_rst_q  <= srt_rst_d;
      srt_now1_q <= srt_now1_d;
      srt_now2_q <= srt_now2_d;
      srt_din_q  <= srt_din_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.src_rd   = src_rd_q;
  assign bus.src_addr = src_addr_q;
  assign bus.dst_we   = dst_we_q;
  assign bus.dst_addr = dst_addr_q;
  assign bus.dst_data = dst_data_q;
  assign bus.srt_rst  = srt_rst_q;
  assign bus.srt_now1 = srt_now1_q;
  assign bus.srt_now2 = srt_now2_q;
  assign bus.srt_din  = srt_din_q;

endmodule

// File: tb/tb_sort_sequencer.sv
// Bench for sort_sequencer: behavioural sorter and buffer models, directed
// scenarios plus randomized jobs checked against a sorted copy of the source.
module tb_sort_sequencer;

  localparam int AW  = 3;
  localparam int DW  = 32;
  localparam int N   = 8;
  localparam int S   = 2;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sort_sequencer_if #(.AW(AW), .DW(DW)) bus ();

  sort_sequencer #(
    .LOG_INPUT_NUM (AW),
    .DATAWIDTH     (DW),
    .SRT_RST_CYCLES(S),
    .TIMEOUT       (TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] src_mem [N];
  logic [DW-1:0] dst_mem [N];
  int wr_tot [N];
  int b_wr   [N];
  int now1_tot = 0, now2_tot = 0, we_tot = 0, done_tot = 0, cyc = 0;
  int b_now1, b_now2, b_we, b_done;
  int last_we_cyc, last_now1_cyc, done_cyc, start_cyc;
  int lat_cfg = 0;

  // Source buffer with one-cycle read latency
  always @(posedge clk) begin
    if (rst) bus.src_data <= '0;
    else if (bus.src_rd) bus.src_data <= src_mem[bus.src_addr];
  end

  // Destination buffer and event counters
  initial foreach (wr_tot[i]) wr_tot[i] = 0;
  always @(posedge clk) begin
    if (bus.start && !bus.busy) foreach (dst_mem[i]) dst_mem[i] = 'x;
    if (bus.start) start_cyc = cyc;
    if (bus.srt_now1) begin now1_tot++; last_now1_cyc = cyc; end
    if (bus.srt_now2) now2_tot++;
    if (bus.dst_we) begin
      dst_mem[bus.dst_addr] = bus.dst_data;
      wr_tot[bus.dst_addr]++;
      we_tot++;
      last_we_cyc = cyc;
    end
    if (bus.done) begin done_tot++; done_cyc = cyc; end
    cyc++;
  end

  // Ascending sorter: collects N loads, presents results after lat_cfg cycles (never if negative)
  logic [DW-1:0] loaded [$];
  logic [DW-1:0] sorted [$];
  int lat_cnt, ptr;
  bit vflag;
  always @(posedge clk) begin
    if (rst || bus.srt_rst) begin
      loaded.delete();
      sorted.delete();
      lat_cnt = 0;
      ptr     = 0;
      vflag   = 1'b0;
    end else begin
      if (bus.srt_now1) loaded.push_back(bus.srt_din);
      if (!vflag && loaded.size() == N && lat_cfg >= 0) begin
        if (lat_cnt >= lat_cfg) begin
          vflag  = 1'b1;
          sorted = loaded;
          sorted.sort();
          ptr    = 0;
        end else begin
          lat_cnt++;
        end
      end
      if (vflag && bus.srt_now2) ptr++;
    end
    bus.srt_y_valid <= vflag && (ptr < N);
    bus.srt_dout    <= (vflag && (ptr < N)) ? sorted[ptr] : '0;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    b_now1 = now1_tot; b_now2 = now2_tot; b_we = we_tot; b_done = done_tot;
    foreach (b_wr[i]) b_wr[i] = wr_tot[i];
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.done === 1'b1) begin got = 1'b1; break; end
      step(1);
    end
    chk({tag, " done_seen"}, 64'(got), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " strobes"}, 64'({bus.busy, bus.done, bus.err, bus.src_rd, bus.dst_we,
                               bus.srt_rst, bus.srt_now1, bus.srt_now2}), 64'd0);
    chk({tag, " addr"}, 64'({bus.src_addr, bus.dst_addr}), 64'd0);
    chk({tag, " data"}, {bus.dst_data, bus.srt_din}, 64'd0);
  endtask

  task automatic check_sorted(input string tag);
    logic [DW-1:0] e [$];
    for (int i = 0; i < N; i++) e.push_back(src_mem[i]);
    e.sort();
    for (int i = 0; i < N; i++)
      chk($sformatf("%s dst[%0d]", tag, i), 64'(dst_mem[i]), 64'(e[i]));
  endtask

  // Completes a started job that is expected to finish normally
  task automatic finish_job(input string tag, input int lat);
    int bad;
    wait_done(tag, 400);
    chk({tag, " err"}, 64'(bus.err), 64'd0);
    step(1);
    chk({tag, " done_len"}, 64'({bus.done, bus.busy}), 64'd0);
    chk({tag, " now1_cnt"}, 64'(now1_tot - b_now1), 64'(N));
    chk({tag, " now2_cnt"}, 64'(now2_tot - b_now2), 64'(N));
    chk({tag, " we_cnt"}, 64'(we_tot - b_we), 64'(N));
    chk({tag, " done_cnt"}, 64'(done_tot - b_done), 64'd1);
    bad = 0;
    for (int i = 0; i < N; i++) if (wr_tot[i] - b_wr[i] != 1) bad++;
    chk({tag, " addr_once"}, 64'(bad), 64'd0);
    chk({tag, " last_we"}, 64'(done_cyc - last_we_cyc), 64'd1);
    if (lat == 0)
      chk({tag, " job_len"}, 64'(done_cyc - start_cyc + 1), 64'(1 + S + (N + 2) + 1 + 2 * N));
    check_sorted(tag);
  endtask

  task automatic sort_job(input string tag, input int lat);
    lat_cfg = lat;
    snap();
    pulse_start();
    finish_job(tag, lat);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    bit seen;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    rst = 1'b1;
    step(3);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Basic job with start-up timing
    src_mem = '{32'd5, 32'd3, 32'd7, 32'd1, 32'd8, 32'd2, 32'd6, 32'd4};
    lat_cfg = 10;
    snap();
    pulse_start();
    chk("t1 busy_srst", 64'({bus.busy, bus.srt_rst}), 64'd3);
    chk("t1 no_rd_early", 64'(bus.src_rd), 64'd0);
    step(S - 1);
    chk("t1 no_rd_last_srst", 64'(bus.src_rd), 64'd0);
    step(1);
    chk("t1 first_rd", 64'({bus.src_rd, bus.src_addr}), 64'({1'b1, 3'd0}));
    step(1);
    chk("t1 now1_not_yet", 64'(bus.srt_now1), 64'd0);
    step(1);
    chk("t1 now1_first", 64'({bus.srt_now1, bus.srt_din}), 64'({1'b1, 32'd5}));
    finish_job("t1", 10);

    // Watchdog timeout, then err cleared by the next start
    lat_cfg = -1;
    snap();
    pulse_start();
    wait_done("t2", 400);
    chk("t2 err_set", 64'(bus.err), 64'd1);
    step(1);
    chk("t2 wait_len", 64'(done_cyc - last_now1_cyc), 64'(TMO + 1));
    chk("t2 no_we", 64'(we_tot - b_we), 64'd0);
    chk("t2 idle", 64'(bus.busy), 64'd0);
    lat_cfg = 3;
    snap();
    pulse_start();
    chk("t2 err_cleared", 64'(bus.err), 64'd0);
    finish_job("t2b", 3);

    // Abort in the third LOAD cycle
    lat_cfg = 3;
    snap();
    pulse_start();
    step(4);
    chk("t3 in_load", 64'(bus.src_rd), 64'd1);
    bus.abort = 1'b1;
    step(1);
    bus.abort = 1'b0;
    chk("t3 fin", 64'({bus.srt_rst, bus.done, bus.busy}), 64'd7);
    chk("t3 strobes_off", 64'({bus.src_rd, bus.srt_now1, bus.srt_now2, bus.dst_we}), 64'd0);
    step(1);
    chk("t3 idle", 64'({bus.busy, bus.done}), 64'd0);
    step(4);
    chk("t3 now1_cnt", 64'(now1_tot - b_now1), 64'd1);
    chk("t3 no_we", 64'(we_tot - b_we), 64'd0);
    chk("t3 done_cnt", 64'(done_tot - b_done), 64'd1);
    chk("t3 err", 64'(bus.err), 64'd0);

    // start during drain is ignored
    src_mem = '{32'd40, 32'd10, 32'd30, 32'd20, 32'd80, 32'd60, 32'd70, 32'd50};
    lat_cfg = 2;
    snap();
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.dst_we === 1'b1) begin seen = 1'b1; break; end
      step(1);
    end
    chk("t4 drain_reached", 64'(seen), 64'd1);
    step(1);
    pulse_start();
    finish_job("t4", 2);
    step(3);
    chk("t4 stays_idle", 64'({bus.busy, bus.srt_rst}), 64'd0);
    chk("t4 one_done", 64'(done_tot - b_done), 64'd1);

    // Reset in WAIT, then a fresh job
    lat_cfg = -1;
    snap();
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (now1_tot - b_now1 == N) begin seen = 1'b1; break; end
      step(1);
    end
    chk("t5 load_done", 64'(seen), 64'd1);
    step(3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check_reset_outputs("t5 rst");
    step(3);
    chk("t5 no_done", 64'(done_tot - b_done), 64'd0);
    src_mem = '{32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    sort_job("t5b", 5);

    // Duplicate keys
    src_mem = '{32'd2, 32'd2, 32'd2, 32'd2, 32'd1, 32'd1, 32'd1, 32'd1};
    sort_job("t6", 1);

    // Randomized jobs; the first uses zero sorter latency for the job-length check
    for (int j = 0; j < 6; j++) begin
      for (int i = 0; i < N; i++) src_mem[i] = $urandom();
      sort_job($sformatf("rnd%0d", j), (j == 0) ? 0 : int'($urandom_range(0, 12)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
